// File: rtl/bus_pkg.sv
// bus_pkg: shared data-bus types and constants.
package bus_pkg;
    localparam int BUS_W = 32;
    localparam logic [BUS_W-1:0] DMEM_BASE_ADDR = 32'h1000_0000;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_e;
endpackage

// File: rtl/ram_1rw.sv
// ram_1rw: single-port word RAM with synchronous read and write.
module ram_1rw #(
    parameter int DEPTH = 256,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else rdata_o <= mem_q[addr_i];
        end
    end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-bus target decoding a word RAM window, with programmable wait states
// and a one-cycle ready/err response.
module data_bus_responder
    import bus_pkg::*;
#(
    parameter logic [BUS_W-1:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int MEM_DEPTH = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             busReq,
    input  logic             busWe,
    input  logic [BUS_W-1:0] busAddr,
    input  logic [BUS_W-1:0] busWData,
    output logic [BUS_W-1:0] busRData,
    output logic             busReady,
    output logic             busErr,
    output logic             busBusy
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = BUS_W + 1;
    localparam logic [LW-1:0] LIMIT = {1'b0, BASE_ADDR} + LW'(4 * MEM_DEPTH);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    bus_state_e state_q;
    logic [3:0] cnt_q;
    logic [BUS_W-1:0] addr_q, wdata_q, acc_addr, acc_wdata, ram_rdata;
    logic [AW-1:0] acc_idx;
    logic we_q, ready_q, err_q, rsel_q, idle, acc_we, acc_hit, commit;

    // The RAM reads synchronously, so it is driven in the cycle whose edge enters RESP;
    // with zero wait states that is the IDLE cycle, before the request is latched.
    assign idle = state_q == IDLE;
    assign acc_addr = idle ? busAddr : addr_q;
    assign acc_wdata = idle ? busWData : wdata_q;
    assign acc_we = idle ? busWe : we_q;
    assign acc_hit = acc_addr >= BASE_ADDR && {1'b0, acc_addr} < LIMIT;
    assign acc_idx = AW'((acc_addr - BASE_ADDR) >> 2);
    assign commit = !reset && (idle ? busReq && WAIT_CYCLES == 0 : state_q == WAIT && cnt_q == 4'd0);

    ram_1rw #(.DEPTH(MEM_DEPTH), .W(BUS_W)) u_ram (
        .clk(clk),
        .en_i(commit && acc_hit),
        .we_i(acc_we),
        .addr_i(acc_idx),
        .wdata_i(acc_wdata),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            rsel_q <= 1'b0;
        end else begin
            ready_q <= commit;
            err_q <= commit && !acc_hit;
            rsel_q <= commit && acc_hit && !acc_we;
            case (state_q)
                IDLE: if (busReq) begin
                    addr_q <= busAddr;
                    we_q <= busWe;
                    wdata_q <= busWData;
                    cnt_q <= WC - 4'd1;
                    state_q <= WAIT_CYCLES == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busRData = rsel_q ? ram_rdata : '0;
    assign busReady = ready_q;
    assign busErr = err_q;
    assign busBusy = !idle;
endmodule
